// File: rtl/fir_lid_param.sv
// rtl/fir_lid_param.sv - programmable FIR on valid/data/stop channels, 4-stage stall-as-a-whole pipe.
// Build option FIR_SATURATE_EN: clamp the rounded result instead of wrapping it to DATA_W.
`timescale 1ns/1ps
module fir_lid_param #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int SHIFT  = 14
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_valid_valid,
  input  logic                      i_valid_data,
  output logic                      i_valid_stop,
  input  logic                      i_data_valid,
  input  logic [DATA_W-1:0]         i_data_data,
  output logic                      i_data_stop,
  output logic                      o_valid_valid,
  output logic                      o_valid_data,
  input  logic                      o_valid_stop,
  output logic                      o_data_valid,
  output logic [DATA_W-1:0]         o_data_data,
  input  logic                      o_data_stop,
  input  logic                      cfg_we,
  input  logic [$clog2(TAPS)-1:0]   cfg_addr,
  input  logic [COEF_W-1:0]         cfg_coef
);

  localparam int PW = DATA_W + COEF_W;
  localparam int SW = PW + $clog2(TAPS);
  localparam logic signed [COEF_W-1:0] ONE  = COEF_W'(1) << SHIFT;
  localparam logic signed [SW:0]       HALF = {{SW{1'b0}}, 1'b1} << (SHIFT - 1);

  logic adv;
  logic acc;

  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [DATA_W-1:0] x    [TAPS];
  logic signed [PW-1:0]     prod [TAPS];
  logic signed [SW-1:0]     sum_next;
  logic signed [SW-1:0]     sum_q;
  logic signed [SW:0]       rnd;
  logic signed [SW:0]       shd;
  logic signed [DATA_W-1:0] res;

  logic v1, v2, v3, out_v;
  logic f1, f2, f3, out_f;
  logic [DATA_W-1:0] out_data;

  // The whole pipe moves in lockstep, so either consumer stop freezes every stage.
  assign adv          = ~(o_valid_stop | o_data_stop);
  assign acc          = adv & i_valid_valid & i_data_valid;
  assign i_valid_stop = ~adv;
  assign i_data_stop  = ~adv;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= (k == 0) ? ONE : '0;
    end else if (cfg_we && (int'(cfg_addr) < TAPS)) begin
      coef[cfg_addr] <= cfg_coef;
    end
  end

  // Bubbles travel down the pipe but leave the delay line untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
    end else if (acc && i_valid_data) begin
      x[0] <= i_data_data;
      for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
    end
  end

  always_comb begin
    sum_next = '0;
    for (int k = 0; k < TAPS; k++) sum_next = sum_next + SW'(prod[k]);
  end

  assign rnd = (SW+1)'(sum_q) + HALF;
  assign shd = rnd >>> SHIFT;

`ifdef FIR_SATURATE_EN
  localparam logic signed [SW:0] MAXV = {{(SW+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW:0] MINV = {{(SW+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

  always_comb begin
    res = shd[DATA_W-1:0];
    if (shd > MAXV)      res = MAXV[DATA_W-1:0];
    else if (shd < MINV) res = MINV[DATA_W-1:0];
  end
`else
  logic unused_hi;

  assign res       = shd[DATA_W-1:0];
  assign unused_hi = ^shd[SW:DATA_W];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) prod[k] <= '0;
      sum_q    <= '0;
      out_data <= '0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      out_v <= 1'b0;
      f1    <= 1'b0;
      f2    <= 1'b0;
      f3    <= 1'b0;
      out_f <= 1'b0;
    end else if (adv) begin
      v1 <= acc;
      f1 <= acc & i_valid_data;
      for (int k = 0; k < TAPS; k++) prod[k] <= PW'(x[k]) * PW'(coef[k]);
      v2       <= v1;
      f2       <= f1;
      sum_q    <= sum_next;
      v3       <= v2;
      f3       <= f2;
      out_data <= res;
      out_v    <= v3;
      out_f    <= f3;
    end
  end

  assign o_valid_valid = out_v;
  assign o_data_valid  = out_v;
  assign o_valid_data  = out_f;
  assign o_data_data   = out_data;

endmodule

// File: doc/fir_lid_param.md
Name: fir_lid_param

Overview:
Parametrised, run-time-programmable FIR filter. It is the next generation of the fixed cascaded FIR and uses the same latency-insensitive channel interface: each port is a channel with valid, data and stop signals. Tap count, data width, coefficient width and output scaling are parameters. Coefficients are loaded through a simple write port. The block sits in the sample datapath between a stream producer and a consumer, and honours downstream backpressure.

Parameters:
DATA_W, 16, sample width (signed, two's complement)
COEF_W, 16, coefficient width (signed)
TAPS, 8, number of filter taps (2..64)
SHIFT, 14, output right-shift (fixed-point scale of coefficients); 1.0 = 1<<SHIFT

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
i_valid_valid  in  1  sample-flag channel token present
i_valid_data  in  1  sample flag: 1 = real sample, 0 = bubble
i_valid_stop  out  1  backpressure to sample-flag producer
i_data_valid  in  1  data channel token present
i_data_data  in  DATA_W  input sample (signed)
i_data_stop  out  1  backpressure to data producer
o_valid_valid  out  1  output flag channel token present
o_valid_data  out  1  output sample flag
o_valid_stop  in  1  consumer stop, flag channel
o_data_valid  out  1  output data token present
o_data_data  out  DATA_W  filtered sample (signed)
o_data_stop  in  1  consumer stop, data channel
cfg_we  in  1  coefficient write strobe
cfg_addr  in  $clog2(TAPS)  tap index
cfg_coef  in  COEF_W  coefficient value (signed)

Behaviour:
- Reset (asynchronous, on reset=0):
  - All outputs low; delay line zero; pipeline empty.
  - Coefficients: c[0]=1<<SHIFT, all others 0 (identity filter).
- Stall and stop:
  - adv = ~(o_valid_stop | o_data_stop).
  - i_valid_stop = i_data_stop = ~adv (combinational).
- Token acceptance:
  - acc = adv & i_valid_valid & i_data_valid.
  - If adv & ~acc, an empty slot enters the pipe; it produces o_*_valid=0 at the output.
- Delay line: on acc & i_valid_data, x[0]<=i_data_data and x[k]<=x[k-1]. Otherwise the delay line holds.
- Pipeline (advances only when adv):
  - S1: delay-line register.
  - S2: TAPS registered products, each DATA_W+COEF_W bits.
  - S3: registered sum of width DATA_W+COEF_W+$clog2(TAPS); no internal overflow.
  - S4 / output register: (sum + (1<<(SHIFT-1))) >>> SHIFT (round-half-up), then reduced to DATA_W (see Optional Feature).
- Latency: 3 advancing cycles from acceptance to o_*_valid=1.
  - o_valid_data carries the accepted i_valid_data flag.
  - For a bubble token (flag 0), o_data_data still reflects the current delay-line filter value.
- Output channels are always driven together: o_valid_valid == o_data_valid.
  - While stopped, the output register and all stages hold; no token is lost or duplicated.
- Coefficient write: cfg_we writes c[cfg_addr] at the clock edge; the value is used by S2 on the next cycle.
  - Write during streaming is permitted; samples in S2 or later keep their old products.
  - cfg_addr >= TAPS is ignored.
- Reset mid-stream: the in-flight tokens are discarded, coefficients return to identity, and the first output after release is the first new accepted token.
- Simultaneous cfg_we and stall: the write still takes effect.

Optional Feature:
FIR_SATURATE_EN
- Defined: the rounded result is clamped to [-(2^(DATA_W-1)), 2^(DATA_W-1)-1].
- Undefined: the low DATA_W bits are taken (two's-complement wrap). This is the smaller-area option.

Test Plan:
- Identity after reset: step 20000 with flags=1, no stops -> o_data_data=20000 from the 3rd cycle after the first acceptance; o_valid_data=1 from that cycle on.
- Impulse: write c[k]=1024*(k+1) for k=0..7, then feed 16384 followed by zeros -> outputs 1024, 2048, ..., 8192, then 0.
- Backpressure: random o_data_stop/o_valid_stop (tied together) at 30% duty on a 200-sample random stream in 0..20000 -> output sequence identical to the no-stop run; i_*_stop equals the stop input each cycle.
- Bubbles: i_valid_data=0 on alternate tokens with identity coefficients -> flagged outputs match the flagged inputs; the delay line does not shift on bubbles.
- Overflow: all c[k]=16384, step 20000 -> 32767 with FIR_SATURATE_EN; 28928 (160000 mod 65536) without it.
- Reset mid-stream: assert reset for 1 cycle at sample 100 -> all outputs 0 immediately; after release, identity passthrough of the new input resumes with latency 3.
